// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: programmable-range modulo counter for the digital-clock
// datapath. Counts up or down on tick_in, supports synchronous preset, hold,
// and wrap or saturate at the bounds. It emits carry/borrow pulses for chaining
// and registered BCD digits that always match count.
module bcd_mod_counter #(
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 59,
  parameter int WIDTH   = 7,
  parameter int RST_VAL = 0,
  parameter int WRAP    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             hold,
  output logic [WIDTH-1:0] count,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones,
  output logic             carry_out,
  output logic             borrow_out,
  output logic             at_limit,
  output logic             load_err
);

  // Bounds are widened by one bit so that +1 at MAX_VAL cannot alias.
  localparam int                W1      = WIDTH + 1;
  localparam logic [WIDTH:0]    MIN_X   = W1'(MIN_VAL);
  localparam logic [WIDTH:0]    MAX_X   = W1'(MAX_VAL);
  localparam logic [WIDTH-1:0]  RST_X   = WIDTH'(RST_VAL);
  localparam logic [3:0]        RST_TEN = 4'(RST_VAL / 10);
  localparam logic [3:0]        RST_ONE = 4'(RST_VAL % 10);
  localparam logic              RST_LIM = (RST_VAL == MAX_VAL);

  logic [WIDTH:0] cnt_ext, ld_ext, nxt_ext;
  logic           carry_nxt, borrow_nxt, err_nxt, lim_nxt;
  logic [3:0]     tens_nxt, ones_nxt;
  int             nxt_int;

  assign cnt_ext = {1'b0, count};
  assign ld_ext  = {1'b0, load_val};

  // Next-state selection: load beats hold beats tick; one action per edge.
  always_comb begin
    nxt_ext    = cnt_ext;
    carry_nxt  = 1'b0;
    borrow_nxt = 1'b0;
    err_nxt    = 1'b0;
    if (load) begin
      if (ld_ext >= MIN_X && ld_ext <= MAX_X) nxt_ext = ld_ext;
      else                                     err_nxt = 1'b1;
    end else if (!hold && tick_in) begin
      if (up_dn) begin
        if (cnt_ext < MAX_X) nxt_ext = cnt_ext + 1'b1;
        else if (WRAP != 0) begin
          nxt_ext   = MIN_X;
          carry_nxt = 1'b1;
        end
      end else begin
        if (cnt_ext > MIN_X) nxt_ext = cnt_ext - 1'b1;
        else if (WRAP != 0) begin
          nxt_ext    = MAX_X;
          borrow_nxt = 1'b1;
        end
      end
    end
  end

  // Digits and limit flag are derived from the next count so they register
  // on the same edge as count and never lag it.
  always_comb begin
    nxt_int  = int'(nxt_ext);
    tens_nxt = 4'(nxt_int / 10);
    ones_nxt = 4'(nxt_int % 10);
    lim_nxt  = up_dn ? (nxt_ext == MAX_X) : (nxt_ext == MIN_X);
  end

  // Output registers; reset behaves as if up_dn were 1 for at_limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count      <= RST_X;
      bcd_tens   <= RST_TEN;
      bcd_ones   <= RST_ONE;
      carry_out  <= 1'b0;
      borrow_out <= 1'b0;
      at_limit   <= RST_LIM;
      load_err   <= 1'b0;
    end else begin
      count      <= nxt_ext[WIDTH-1:0];
      bcd_tens   <= tens_nxt;
      bcd_ones   <= ones_nxt;
      carry_out  <= carry_nxt;
      borrow_out <= borrow_nxt;
      at_limit   <= lim_nxt;
      load_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Scoreboard bench for bcd_mod_counter: three instances (0..59 wrap,
// 12-hour 1..12 wrap, 0..59 saturate) share one stimulus stream. The driver
// pushes model predictions; a negedge monitor pops and compares them.
module tb_bcd_mod_counter;

  typedef struct {
    int cnt, tens, ones;
    bit cy, bw, al, er;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_in = 1'b0, up_dn = 1'b1, load = 1'b0, hold = 1'b0;
  logic [6:0] load_val = '0;

  logic [6:0] cnt_o  [3];
  logic [3:0] tens_o [3];
  logic [3:0] ones_o [3];
  logic [2:0] cy_o, bw_o, al_o, er_o;

  int lo_p [3] = '{0, 1, 0};
  int hi_p [3] = '{59, 12, 59};
  int wr_p [3] = '{1, 1, 0};
  int rv_p [3] = '{0, 12, 0};
  int cur  [3];

  exp_t q0[$], q1[$], q2[$];
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  bcd_mod_counter #(.MIN_VAL(0), .MAX_VAL(59), .WIDTH(7), .RST_VAL(0), .WRAP(1)) u0 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .up_dn(up_dn), .load(load),
    .load_val(load_val), .hold(hold), .count(cnt_o[0]), .bcd_tens(tens_o[0]),
    .bcd_ones(ones_o[0]), .carry_out(cy_o[0]), .borrow_out(bw_o[0]),
    .at_limit(al_o[0]), .load_err(er_o[0]));

  bcd_mod_counter #(.MIN_VAL(1), .MAX_VAL(12), .WIDTH(7), .RST_VAL(12), .WRAP(1)) u1 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .up_dn(up_dn), .load(load),
    .load_val(load_val), .hold(hold), .count(cnt_o[1]), .bcd_tens(tens_o[1]),
    .bcd_ones(ones_o[1]), .carry_out(cy_o[1]), .borrow_out(bw_o[1]),
    .at_limit(al_o[1]), .load_err(er_o[1]));

  bcd_mod_counter #(.MIN_VAL(0), .MAX_VAL(59), .WIDTH(7), .RST_VAL(0), .WRAP(0)) u2 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .up_dn(up_dn), .load(load),
    .load_val(load_val), .hold(hold), .count(cnt_o[2]), .bcd_tens(tens_o[2]),
    .bcd_ones(ones_o[2]), .carry_out(cy_o[2]), .borrow_out(bw_o[2]),
    .at_limit(al_o[2]), .load_err(er_o[2]));

  // Reference model: ring arithmetic over the span [lo, hi].
  function automatic exp_t model(input int k, input int c, input bit t, u, l,
                                 input int lv, input bit h);
    exp_t e;
    int   lo = lo_p[k], hi = hi_p[k], span = hi_p[k] - lo_p[k] + 1;
    int   n  = c;
    e.cy = 0; e.bw = 0; e.er = 0;
    if (l) begin
      if (lv >= lo && lv <= hi) n = lv;
      else e.er = 1;
    end else if (!h && t) begin
      if (u) begin
        if (c == hi && wr_p[k] == 0) n = c;
        else begin n = lo + (c - lo + 1) % span; e.cy = (c == hi); end
      end else begin
        if (c == lo && wr_p[k] == 0) n = c;
        else begin n = lo + (c - lo + span - 1) % span; e.bw = (c == lo); end
      end
    end
    e.cnt = n; e.tens = n / 10; e.ones = n % 10;
    e.al = u ? (n == hi) : (n == lo);
    return e;
  endfunction

  function automatic exp_t rst_exp(input int k);
    exp_t e;
    e.cnt = rv_p[k]; e.tens = rv_p[k] / 10; e.ones = rv_p[k] % 10;
    e.cy = 0; e.bw = 0; e.er = 0; e.al = (rv_p[k] == hi_p[k]);
    return e;
  endfunction

  task automatic push(input int k, input exp_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // One compare of all outputs of instance k against a prediction.
  task automatic chk(input int k, input exp_t e);
    bit ok;
    ok = (int'(cnt_o[k]) == e.cnt) && (int'(tens_o[k]) == e.tens) &&
         (int'(ones_o[k]) == e.ones) && (cy_o[k] == e.cy) && (bw_o[k] == e.bw) &&
         (al_o[k] == e.al) && (er_o[k] == e.er);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL outputs_u%0d t=%0t got cnt=%0d bcd=%0d/%0d cy=%0b bw=%0b al=%0b er=%0b want cnt=%0d bcd=%0d/%0d cy=%0b bw=%0b al=%0b er=%0b",
                  k, $time, cnt_o[k], tens_o[k], ones_o[k], cy_o[k], bw_o[k], al_o[k], er_o[k],
                  e.cnt, e.tens, e.ones, e.cy, e.bw, e.al, e.er);
  endtask

  // Monitor: every cycle presents a result; compare it on the falling edge.
  always @(negedge clk) begin
    if (q0.size() > 0) chk(0, q0.pop_front());
    if (q1.size() > 0) chk(1, q1.pop_front());
    if (q2.size() > 0) chk(2, q2.pop_front());
  end

  // Drive one cycle of inputs and predict the state after the next edge.
  task automatic cycle(input bit t, u, l, input int lv, input bit h, input bit r);
    @(negedge clk); #1;
    rst = r; tick_in = t; up_dn = u; load = l; load_val = 7'(lv); hold = h;
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      e = r ? rst_exp(k) : model(k, cur[k], t, u, l, lv, h);
      cur[k] = e.cnt;
      push(k, e);
    end
  endtask

  // Assert reset mid-cycle, check it takes effect before any edge.
  task automatic async_rst();
    @(negedge clk); #3;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if (int'(cnt_o[k]) == rv_p[k] && cy_o[k] == 1'b0) n_pass++;
      else $display("FAIL async_rst_u%0d got cnt=%0d cy=%0b want cnt=%0d cy=0",
                    k, cnt_o[k], cy_o[k], rv_p[k]);
    end
    q0.delete(); q1.delete(); q2.delete();
    for (int k = 0; k < 3; k++) begin
      cur[k] = rv_p[k];
      push(k, rst_exp(k));
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) cur[k] = rv_p[k];
    // Reset held over two edges, then release.
    cycle(0, 1, 0, 0, 0, 1);
    cycle(1, 1, 0, 0, 0, 1);
    // 60 ticks up: full wrap on u0, 12-hour wrap on u1, saturation on u2.
    for (int i = 0; i < 60; i++) cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    // 12-hour borrow: set u1 to 1 (u0/u2 also accept 1), then down-tick.
    cycle(0, 1, 1, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    // Preset in range then out of range.
    cycle(0, 1, 1, 45, 0, 0);
    cycle(1, 1, 1, 75, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    // Hold with ticks dropped, then release for a single +1.
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 1, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    // Saturation at 59, then step down.
    cycle(0, 1, 1, 59, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    // Load coinciding with a wrap condition: load wins, no pulse.
    cycle(0, 1, 1, 12, 0, 0);
    cycle(1, 1, 1, 5, 0, 0);
    // Back-to-back from 57, reset mid-cycle at 59 before the wrap edge.
    cycle(0, 1, 1, 57, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    async_rst();
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0, 0);
    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      bit t, u, l, h;
      int lv;
      t  = ($urandom_range(0, 99) < 60);
      u  = ($urandom_range(0, 99) < 65);
      l  = ($urandom_range(0, 99) < 5);
      h  = ($urandom_range(0, 99) < 10);
      lv = $urandom_range(0, 127);
      if ($urandom_range(0, 499) == 0) async_rst();
      else cycle(t, u, l, lv, h, 0);
    end
    cycle(0, 1, 0, 0, 0, 0);
    @(negedge clk); #2;
    n_chk++;
    if (q0.size() == 0 && q1.size() == 0 && q2.size() == 0) n_pass++;
    else $display("FAIL drain got pending=%0d/%0d/%0d want 0/0/0", q0.size(), q1.size(), q2.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
